sc_collision_scan: RTL
======================

SC_COLLISION_SCAN -- requirements
Module: SC_COLLISION_SCAN

Interface
REQ-001 Parameter ROW_WIDTH, default 8: bit width of one playfield row.
REQ-002 Parameter NUM_ROWS, default 8, minimum 2: rows per scan. IDX_W = clog2(NUM_ROWS), derived and not overridable.
REQ-003 SC_COLLISION_SCAN_CLOCK_50  in  1  single clock; all state changes on the rising edge.
REQ-004 SC_COLLISION_SCAN_RESET_InLow  in  1  asynchronous, active-low reset.
REQ-005 Start_In  in  1  scan request; sampled only in IDLE.
REQ-006 Clear_In  in  1  clears the sticky collision results.
REQ-007 Pointrow_In  in  ROW_WIDTH  frog (point) row data for RowAddr_Out, valid in the same cycle.
REQ-008 Backrow_In  in  ROW_WIDTH  background (traffic) row data for RowAddr_Out, valid in the same cycle.
REQ-009 Ready_In  in  1  downstream accepts Merge_Out.
REQ-010 RowAddr_Out  out  IDX_W  row currently requested from the register banks.
REQ-011 Merge_Out  out  ROW_WIDTH  registered Pointrow OR Backrow.
REQ-012 MergeRow_Out  out  IDX_W  row index of Merge_Out.
REQ-013 MergeValid_Out  out  1  Merge_Out is valid.
REQ-014 Collision_Out  out  1  sticky: any row had Pointrow AND Backrow nonzero.
REQ-015 CollisionRow_Out  out  IDX_W  first colliding row of the current or latest scan.
REQ-016 HitCount_Out  out  IDX_W+1  number of colliding rows in the current or latest scan.
REQ-017 Busy_Out  out  1  high in SCAN and DONE. Done_Out  out  1  one-cycle end-of-scan pulse.

Function
REQ-018 FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on Start_In=1: row counter=0, HitCount=0, CollisionRow=0.
  - SCAN -> DONE on capture of row NUM_ROWS-1.
  - DONE -> IDLE in the cycle Done_Out is asserted.
REQ-019 Capture condition: state SCAN and (MergeValid_Out=0 or Ready_In=1).
  - On capture: Merge_Out <= Pointrow|Backrow; MergeRow_Out <= row; MergeValid_Out <= 1; row counter increments.
REQ-020 If MergeValid_Out=1, Ready_In=1 and no capture occurs, MergeValid_Out <= 0. While MergeValid_Out=1 and Ready_In=0, Merge_Out, MergeRow_Out and RowAddr_Out hold; no row is skipped or repeated.
REQ-021 Latency: Start sampled at cycle t -> RowAddr_Out=0 in t+1 -> row 0 valid in t+2. With Ready_In held at 1, row NUM_ROWS-1 is valid and Done_Out=1 in t+NUM_ROWS+1.
REQ-022 Done_Out is asserted in DONE only when MergeValid_Out=0 or Ready_In=1, i.e. the last row has drained.
REQ-023 Collision on capture means the captured rows ANDed together are nonzero. On a collision:
  - Collision_Out <= 1.
  - HitCount increments, saturating at NUM_ROWS.
  - If HitCount was 0, CollisionRow_Out <= row.
REQ-024 Clear_In=1 zeroes Collision_Out, HitCount_Out and CollisionRow_Out. If a collision is captured in the same cycle, the capture wins: Collision_Out=1, HitCount=1, CollisionRow=row.
REQ-025 Start_In is ignored in SCAN and DONE. Collision_Out persists across scans until Clear_In or reset.
REQ-026 RowAddr_Out reads 0 in IDLE. The row counter does not wrap within a scan.

Reset
REQ-027 While SC_COLLISION_SCAN_RESET_InLow=0:
  - State = IDLE.
  - Every output and every internal register = 0.
REQ-028 A reset asserted mid-scan aborts the scan with no Done_Out. The next Start_In scans from row 0.

Structure
REQ-029 The shared package SC_COLLISION_PKG holds the FSM state encodings (2 bits) and the default ROW_WIDTH and NUM_ROWS constants.
REQ-030 One sub-module, CC_ROWGATES, is parametrised by ROW_WIDTH and combinationally produces the row AND and the row OR. The FSM, counter and output registers reside in SC_COLLISION_SCAN.

Verification (ROW_WIDTH=8, NUM_ROWS=8)
REQ-031 Clean scan: all Pointrows 0 except row 2 = 0x10; all Backrows 0x0F; Ready_In=1.
  - Row 2 Merge_Out=0x1F; all other rows 0x0F.
  - Collision_Out=0, HitCount_Out=0.
  - Done_Out exactly 9 cycles after Start.
REQ-032 Collisions: row 5 Point 0x08/Back 0x18; row 6 Point 0x01/Back 0x01.
  - Collision_Out=1, CollisionRow_Out=5, HitCount_Out=2.
  - Row 5 Merge_Out=0x18.
REQ-033 Backpressure: Ready_In=0 for 3 cycles while row 2 is valid.
  - Merge_Out and MergeRow_Out=2 are stable; RowAddr_Out holds 3.
  - All 8 rows are delivered in order; Done_Out at cycle 12 after Start.
REQ-034 Clear_In pulsed in the same cycle as the row-5 collision capture -> Collision_Out=1, HitCount_Out=1.
REQ-035 Reset pulse while RowAddr_Out=3 -> all outputs 0 and no Done_Out. A new Start produces 8 rows starting at row 0.
REQ-036 Start_In held high throughout a scan -> exactly one scan and one Done_Out until IDLE is re-entered.

Source files
------------

// File: rtl/sc_collision_pkg.sv
// Shared definitions for the collision scanner: FSM encoding and default geometry.
package sc_collision_pkg;

    localparam int DEF_ROW_WIDTH = 8;
    localparam int DEF_NUM_ROWS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/cc_rowgates.sv
// Per-row combinational gates: overlap (AND) and merged image (OR) of point and background rows.
module cc_rowgates #(
    parameter int ROW_WIDTH = 8
) (
    input  logic [ROW_WIDTH-1:0] point_i,
    input  logic [ROW_WIDTH-1:0] back_i,
    output logic [ROW_WIDTH-1:0] and_o,
    output logic [ROW_WIDTH-1:0] or_o
);

    assign and_o = point_i & back_i;
    assign or_o  = point_i | back_i;

endmodule

// File: rtl/sc_collision_scan.sv
// Walks all playfield rows, streams the merged image with valid/ready flow control
// and records sticky collision results (first colliding row, hit count).
module sc_collision_scan
    import sc_collision_pkg::*;
#(
    parameter  int ROW_WIDTH = DEF_ROW_WIDTH,
    parameter  int NUM_ROWS  = DEF_NUM_ROWS,
    localparam int IDX_W     = $clog2(NUM_ROWS)
) (
    input  logic                 SC_COLLISION_SCAN_CLOCK_50,
    input  logic                 SC_COLLISION_SCAN_RESET_InLow,
    input  logic                 Start_In,
    input  logic                 Clear_In,
    input  logic [ROW_WIDTH-1:0] Pointrow_In,
    input  logic [ROW_WIDTH-1:0] Backrow_In,
    input  logic                 Ready_In,
    output logic [IDX_W-1:0]     RowAddr_Out,
    output logic [ROW_WIDTH-1:0] Merge_Out,
    output logic [IDX_W-1:0]     MergeRow_Out,
    output logic                 MergeValid_Out,
    output logic                 Collision_Out,
    output logic [IDX_W-1:0]     CollisionRow_Out,
    output logic [IDX_W:0]       HitCount_Out,
    output logic                 Busy_Out,
    output logic                 Done_Out
);

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_ROWS - 1);
    localparam logic [IDX_W:0]   HIT_MAX  = (IDX_W + 1)'(NUM_ROWS);

    scan_state_e          state_q, state_d;
    logic [IDX_W-1:0]     row_q, row_d;
    logic [ROW_WIDTH-1:0] merge_q, merge_d;
    logic [IDX_W-1:0]     mrow_q, mrow_d;
    logic                 mvalid_q, mvalid_d;
    logic                 coll_q, coll_d;
    logic [IDX_W-1:0]     crow_q, crow_d;
    logic [IDX_W:0]       hit_q, hit_d;
    logic [ROW_WIDTH-1:0] row_and, row_or;
    logic                 capture, hit_row, done;

    cc_rowgates #(.ROW_WIDTH(ROW_WIDTH)) u_rowgates (
        .point_i (Pointrow_In),
        .back_i  (Backrow_In),
        .and_o   (row_and),
        .or_o    (row_or)
    );

    // A row is taken whenever the output slot is empty or being drained this cycle.
    assign capture = (state_q == ST_SCAN) && (!mvalid_q || Ready_In);
    assign hit_row = capture && (|row_and);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        row_d    = row_q;
        merge_d  = merge_q;
        mrow_d   = mrow_q;
        mvalid_d = mvalid_q;
        coll_d   = coll_q;
        crow_d   = crow_q;
        hit_d    = hit_q;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start_In) begin
                    state_d = ST_SCAN;
                    row_d   = '0;
                    hit_d   = '0;
                    crow_d  = '0;
                end
            end
            ST_SCAN: begin
                if (capture) begin
                    if (row_q == LAST_ROW) state_d = ST_DONE;
                    else                   row_d   = row_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (!mvalid_q || Ready_In) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    row_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            merge_d  = row_or;
            mrow_d   = row_q;
            mvalid_d = 1'b1;
        end else if (mvalid_q && Ready_In) begin
            mvalid_d = 1'b0;
        end

        if (Clear_In) begin
            coll_d = 1'b0;
            hit_d  = '0;
            crow_d = '0;
        end

        // Applied after the clear so a same-cycle collision survives it.
        if (hit_row) begin
            coll_d = 1'b1;
            if (hit_d == '0)     crow_d = row_q;
            if (hit_d != HIT_MAX) hit_d = hit_d + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge SC_COLLISION_SCAN_CLOCK_50 or negedge SC_COLLISION_SCAN_RESET_InLow) begin
        if (!SC_COLLISION_SCAN_RESET_InLow) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            merge_q  <= '0;
            mrow_q   <= '0;
            mvalid_q <= 1'b0;
            coll_q   <= 1'b0;
            crow_q   <= '0;
            hit_q    <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            merge_q  <= merge_d;
            mrow_q   <= mrow_d;
            mvalid_q <= mvalid_d;
            coll_q   <= coll_d;
            crow_q   <= crow_d;
            hit_q    <= hit_d;
        end
    end

    assign RowAddr_Out      = row_q;
    assign Merge_Out        = merge_q;
    assign MergeRow_Out     = mrow_q;
    assign MergeValid_Out   = mvalid_q;
    assign Collision_Out    = coll_q;
    assign CollisionRow_Out = crow_q;
    assign HitCount_Out     = hit_q;
    assign Busy_Out         = (state_q != ST_IDLE);
    assign Done_Out         = done;

endmodule
